// File: rtl/spi_ram_sender.sv
// SPI master (mode 0, MSB first) that streams bytes 0..len-1 of a
// synchronous-read source memory out as one chip-select-framed write burst.
// Byte k of the burst lands at loader address k, so the burst is the image.
module spi_ram_sender #(
  parameter int AW      = 8,  // source address width; bursts up to 2^AW bytes
  parameter int CLK_DIV = 2   // i_clk cycles per SCLK half-period (1..255)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW:0]   i_len,
  output logic [AW-1:0] o_mem_raddr,
  output logic          o_mem_ren,
  input  logic [7:0]    i_mem_rdata,
  output logic          o_sclk,
  output logic          o_cs_n,
  output logic          o_mosi,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_END
  } state_t;

  state_t        state, state_nx;
  logic [AW:0]   len_q;
  logic [AW-1:0] addr;
  logic [2:0]    bit_cnt;
  logic [7:0]    div_cnt;
  // Only the seven bits still to be sent are kept; bit 7 goes straight to MOSI.
  logic [6:0]    shreg;

  logic sclk_nx, cs_n_nx, mosi_nx, busy_nx, done_nx;
  logic accept, div_last, bit_last, more_bytes;
  logic [AW:0] addr_inc;

  assign accept     = (state == S_IDLE) && i_start && (i_len != '0);
  assign div_last   = (div_cnt == 8'(CLK_DIV - 1));
  assign bit_last   = (bit_cnt == 3'd7);
  assign addr_inc   = {1'b0, addr} + {{AW{1'b0}}, 1'b1};
  // Compared at AW+1 bits so a full 2^AW burst ends before addr could wrap.
  assign more_bytes = (addr_inc < len_q);

  // Read port is decoded directly so data is back for LOAD one cycle later.
  assign o_mem_ren   = (state == S_FETCH);
  assign o_mem_raddr = addr;

  // State register and registered SPI/handshake outputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      o_sclk <= 1'b0;
      o_cs_n <= 1'b1;
      o_mosi <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nx;
      o_sclk <= sclk_nx;
      o_cs_n <= cs_n_nx;
      o_mosi <= mosi_nx;
      o_busy <= busy_nx;
      o_done <= done_nx;
    end
  end

  // Next-state decode: byte loop FETCH->LOAD->(LOW/HIGH)x8, then END.
  always_comb begin
    // NOTE: default first so every path assigns state_nx; no latch inferred.
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_FETCH;
      S_FETCH: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_LOW;
      S_LOW:   if (div_last) state_nx = S_HIGH;
      S_HIGH:
        if (div_last) begin
          if (!bit_last)       state_nx = S_LOW;
          else if (more_bytes) state_nx = S_FETCH;
          else                 state_nx = S_END;
        end
      S_END:   if (div_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; MOSI only moves with SCLK low.
  always_comb begin
    sclk_nx = (state_nx == S_HIGH);
    cs_n_nx = o_cs_n;
    mosi_nx = o_mosi;
    busy_nx = o_busy;
    done_nx = 1'b0;
    unique case (state)
      S_IDLE: if (accept) busy_nx = 1'b1;
      S_LOAD: begin
        cs_n_nx = 1'b0;
        mosi_nx = i_mem_rdata[7];
      end
      S_HIGH: if (div_last && !bit_last) mosi_nx = shreg[6];
      S_END:
        if (div_last) begin
          cs_n_nx = 1'b1;
          mosi_nx = 1'b0;
          busy_nx = 1'b0;
          done_nx = 1'b1;
        end
      default: ;
    endcase
  end

  // Datapath: length latch, address/bit/divider counters, shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q   <= '0;
      addr    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (accept) begin
            len_q   <= i_len;
            addr    <= '0;
            bit_cnt <= '0;
          end
        S_LOAD: begin
          shreg   <= i_mem_rdata[6:0];
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        S_LOW, S_END: div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
        S_HIGH:
          if (div_last) begin
            div_cnt <= '0;
            if (!bit_last) begin
              shreg   <= {shreg[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end else if (more_bytes) begin
              addr <= addr_inc[AW-1:0];
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_ram_sender.md
Name: spi_ram_sender

Overview:
SPI master that streams a byte image out of a local synchronous-read memory as a mode-0, MSB-first SPI write burst.
- It is the upstream stage of the SPI RAM loader: one burst (cs_n low) places byte k of the source memory at loader SRAM address k, starting at 0.
- Used for host-side/boot image transfer and as the stimulus driver in loader benches.

Parameters:
AW, 8, source memory address width; maximum burst length is 2^AW bytes.
CLK_DIV, 2, i_clk cycles per SCLK half-period. Legal range is 1 to 255.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start request; sampled only in IDLE
i_len  input  AW+1  burst length in bytes; 0 means no transfer
o_mem_raddr  output  AW  source memory read address
o_mem_ren  output  1  source memory read enable
i_mem_rdata  input  8  read data, valid the cycle after o_mem_ren
o_sclk  output  1  SPI clock, idle low
o_cs_n  output  1  SPI chip select, active low
o_mosi  output  1  SPI data, MSB first
o_busy  output  1  high from start accept until done
o_done  output  1  one-cycle pulse at end of burst

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. All outputs are registered except o_mem_ren and o_mem_raddr, which are decoded from state and the address counter.
- Reset (asynchronous, active-low):
  - State is IDLE.
  - o_cs_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_mem_ren=0, o_mem_raddr=0.
  - Asserting reset mid-burst raises o_cs_n immediately, which aborts the loader cleanly.
- States: IDLE, FETCH, LOAD, LOW, HIGH, END.
- IDLE:
  - On i_start=1 and i_len!=0: latch len, clear addr and bit counters, set busy=1, go to FETCH.
  - i_start with i_len=0 is ignored: no busy, no done.
  - i_start in any state other than IDLE is ignored.
- FETCH (1 cycle):
  - o_mem_ren=1, o_mem_raddr=addr.
  - o_sclk=0; o_cs_n keeps its current value.
- LOAD (1 cycle):
  - At the end of the cycle, capture i_mem_rdata into the shift register.
  - Set o_mosi=rdata[7], o_cs_n=0, bit=0, divider=0, then go to LOW.
- LOW (CLK_DIV cycles):
  - o_sclk=0, then go to HIGH with o_sclk=1.
- HIGH (CLK_DIV cycles):
  - o_sclk=1. On the last cycle, o_sclk returns to 0 and one of:
    - bit<7: shift left, o_mosi=next bit, bit+1, go to LOW.
    - bit==7 and addr+1<len: addr+1, go to FETCH. cs_n stays low, sclk stays low, mosi holds.
    - bit==7 and last byte: go to END.
- END (CLK_DIV cycles):
  - o_sclk=0, o_cs_n=0 (cs hold time).
  - Then set o_cs_n=1, o_mosi=0, o_busy=0, pulse o_done for 1 cycle, return to IDLE.
- MOSI only changes while SCLK is low or at the falling-edge cycle. It is stable across every rising edge.
- Burst invariants:
  - Exactly 8*len SCLK rising edges per burst.
  - Reads are issued to addresses 0..len-1 in order.
- Cycle count from the cycle i_start is accepted to the o_done cycle is len*(2+16*CLK_DIV)+CLK_DIV.
- len=2^AW (i_len MSB set, others 0) is legal. The addr counter never wraps because the burst terminates first.

Test Plan:
- AW=4, CLK_DIV=2, mem[0]=0xA5, start with len=1:
  - ren asserted once at addr 0.
  - cs_n low for 34 cycles; o_done 36 cycles after start accepted.
  - MOSI at the 8 rising edges is 1,0,1,0,0,1,0,1.
- len=3, mem={0x12,0x34,0xFF}, loader model on same clock:
  - Loader writes 0x12@0, 0x34@1, 0xFF@2.
  - 24 rising edges total; cs_n stays low across the byte gaps; done at cycle 104.
- CLK_DIV=1, len=16, mem[i]=i^0x5A:
  - Full-depth burst; loader image matches; no address wrap.
  - Each byte takes 18 cycles.
- start with len=0 -> busy stays 0, cs_n stays 1, no ren, no done. start pulsed while busy -> ignored; burst length unchanged.
- Assert i_rst_n=0 mid-byte 1, bit 4 -> cs_n=1 and sclk=0 asynchronously. After release, a new len=2 burst writes loader addresses 0 and 1 correctly.
- Check MOSI stability: the bench asserts o_mosi is unchanged on every cycle where o_sclk is, or becomes, 1. Covered for CLK_DIV values 1, 2 and 5.
